// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg
//   Shared definitions for the fetch/PC unit of the 5-stage MIPS core:
//   fetch state encoding, PC increment, bubble instruction and a helper
//   that forces a redirect address onto a word boundary.
// ---------------------------------------------------------------------------
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request outstanding at pc
        S_DRAIN = 2'd1,   // wrong-path request still on the bus, waiting for its ack
        S_HOLD  = 2'd2    // fetched word parked while the hazard unit stalls
    } state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pc_next_sel
//   Combinational redirect decision and target select.
//   Ports:
//     stall          in   hazard stall (suppresses a jump, never a branch)
//     branch_taken   in   EX-stage branch resolved taken
//     branch_target  in   EX-stage branch address
//     jump           in   ID-stage jump decoded
//     jump_target    in   ID-stage jump address
//     redirect       out  fetch stream must change direction this cycle
//     target         out  word-aligned redirect address
// ---------------------------------------------------------------------------
module fetch_pc_unit_pc_next_sel
    import fetch_pc_unit_pkg::*;
(
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] target
);

    // A stalled ID-stage jump will be presented again next cycle, so it is
    // ignored now. The branch is older than the jump and always wins.
    assign redirect = branch_taken | (jump & ~stall);
    assign target   = align_word(branch_taken ? branch_target : jump_target);

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   PC register, instruction-fetch handshake and IF/ID register.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     stall                    hazard unit: hold PC and IF/ID
//     branch_taken/_target     EX-stage branch resolution
//     jump/jump_target         ID-stage jump
//     imem_req/imem_addr       fetch request, held with a stable address until ack
//     imem_ack/imem_rdata      memory accept, data valid in the ack cycle
//     pc_out                   current fetch PC
//     ifid_valid/_instr/_next_pc   IF/ID register (next_pc = fetch PC + 4)
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_next_pc
);

    import fetch_pc_unit_pkg::*;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;   // redirect target waiting for the wrong-path ack
    logic [31:0] hold_instr;   // word accepted during a stall
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    fetch_pc_unit_pc_next_sel u_pc_next_sel (
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target)
    );

    // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4  = pc + PC_INC;

    assign imem_req  = ((state == S_FETCH) || (state == S_DRAIN)) && !rst;
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            pending_pc   <= '0;
            hold_instr   <= '0;
            ifid_valid   <= 1'b0;
            ifid_instr   <= NOP_INSTR;
            ifid_next_pc <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Fetched word is on the wrong path.
                            pc         <= target;
                            ifid_valid <= 1'b0;
                        end else if (stall) begin
                            hold_instr <= imem_rdata;
                            state      <= S_HOLD;
                        end else begin
                            ifid_instr   <= imem_rdata;
                            ifid_next_pc <= pc_plus4;
                            ifid_valid   <= 1'b1;
                            pc           <= pc_plus4;
                        end
                    end else if (redirect) begin
                        // Request already on the bus: keep the address stable
                        // and retire it before moving to the target.
                        pending_pc <= target;
                        ifid_valid <= 1'b0;
                        state      <= S_DRAIN;
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        pending_pc <= target;
                        ifid_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        // Latest redirect wins, including one arriving with the ack.
                        pc    <= redirect ? target : pending_pc;
                        state <= S_FETCH;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc         <= target;
                        ifid_valid <= 1'b0;
                        state      <= S_FETCH;
                    end else if (!stall) begin
                        ifid_instr   <= hold_instr;
                        ifid_next_pc <= pc_plus4;
                        ifid_valid   <= 1'b1;
                        pc           <= pc_plus4;
                        state        <= S_FETCH;
                    end
                end

                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed scenarios followed by randomized traffic, all checked against a
//   flag-based reference model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_out;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_next_pc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_out        (pc_out),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_next_pc  (ifid_next_pc)
    );

    always #5 clk = ~clk;

    // Reference model: the fetch stream as a handful of facts.
    logic [31:0] m_pc;
    bit          m_wrong;      // request on the bus belongs to a discarded path
    logic [31:0] m_redir;      // where to go once that request retires
    bit          m_held;       // a word is parked while stalled
    logic [31:0] m_hold;
    bit          m_v;
    logic [31:0] m_instr;
    logic [31:0] m_npc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit st, input bit bt, input logic [31:0] bta,
                                input bit j, input logic [31:0] jta, input bit ack,
                                input logic [31:0] word);
        bit          rd;
        logic [31:0] tg;
        if (r) begin
            m_pc = 32'h0; m_wrong = 0; m_redir = '0; m_held = 0; m_hold = '0;
            m_v = 0; m_instr = 32'h0; m_npc = 32'h0;
            return;
        end
        rd = bt || (j && !st);
        tg = (bt ? bta : jta) & 32'hFFFF_FFFC;
        if (m_held) begin
            if (rd) begin
                m_held = 0; m_pc = tg; m_v = 0;
            end else if (!st) begin
                m_held = 0; m_v = 1; m_instr = m_hold; m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end
        end else if (rd) begin
            m_v = 0;
            if (ack) begin
                m_pc = tg; m_wrong = 0;
            end else begin
                m_wrong = 1; m_redir = tg;
            end
        end else if (m_wrong) begin
            if (ack) begin
                m_pc = m_redir; m_wrong = 0;
            end
        end else if (ack) begin
            if (st) begin
                m_held = 1; m_hold = word;
            end else begin
                m_v = 1; m_instr = word; m_npc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end
        end else if (!st) begin
            m_v = 0;
        end
    endtask

    // One clock: drive at negedge, check the request before the edge,
    // check registered state at the following negedge.
    task automatic step(input bit r, input bit st, input bit bt, input logic [31:0] bta,
                        input bit j, input logic [31:0] jta, input bit ack_en);
        bit          exp_req;
        bit          ack;
        logic [31:0] word;
        exp_req = !m_held && !r;
        ack     = ack_en && exp_req;
        word    = ack ? mem_word(m_pc) : $urandom;
        rst = r; stall = st; branch_taken = bt; branch_target = bta;
        jump = j; jump_target = jta; imem_ack = ack; imem_rdata = word;
        #1;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_update(r, st, bt, bta, j, jta, ack, word);
        @(negedge clk);
        chk("pc_out", pc_out, m_pc);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
        if (m_v || r) begin
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_next_pc", ifid_next_pc, m_npc);
        end
    endtask

    task automatic idle(input bit st, input bit ack_en);
        step(1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0, ack_en);
    endtask

    initial begin
        m_pc = '0; m_wrong = 0; m_redir = '0; m_held = 0; m_hold = '0;
        m_v = 0; m_instr = '0; m_npc = '0;
        @(negedge clk);

        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_next_pc", ifid_next_pc, 32'h0);

        // Zero-wait streaming
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0, 1'b1);
            chk("t1_pc", pc_out, 32'(4 * i));
            chk("t1_next_pc", ifid_next_pc, 32'(4 * i));
        end

        // Taken branch with unaligned target
        step(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0, 1'b1);
        chk("t2_pc", pc_out, 32'h0000_0100);
        chk("t2_valid", {31'd0, ifid_valid}, 32'd0);

        // Redirect while the fetch is still waiting
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
        chk("t3_hold_addr", pc_out, 32'h0000_0100);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("t3_still_old", pc_out, 32'h0000_0100);
        idle(1'b0, 1'b1);
        chk("t3_pc", pc_out, 32'h0000_0040);
        chk("t3_valid", {31'd0, ifid_valid}, 32'd0);

        // Stall while a word arrives at pc 8
        step(1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0, 1'b1);
        idle(1'b1, 1'b1);
        chk("t4_req_hold", {31'd0, imem_req}, 32'd0);
        idle(1'b1, 1'b1);
        chk("t4_req_hold2", {31'd0, imem_req}, 32'd0);
        idle(1'b0, 1'b1);
        chk("t4_instr", ifid_instr, mem_word(32'h0000_0008));
        chk("t4_next_pc", ifid_next_pc, 32'h0000_000C);
        chk("t4_pc", pc_out, 32'h0000_000C);

        // Stalled jump ignored; branch beats jump
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
        chk("t5_jump_ignored", pc_out, 32'h0000_000C);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0200, 1'b1);
        chk("t5_branch_wins", pc_out, 32'h0000_0300);

        // PC wrap and reset during a drain
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        idle(1'b0, 1'b1);
        chk("t6_wrap", pc_out, 32'h0);
        chk("t6_wrap_next_pc", ifid_next_pc, 32'h0);
        idle(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_rst_pc", pc_out, 32'h0);
        chk("t6_rst_valid", {31'd0, ifid_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 1) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
